// File: rtl/speck_iter_encrypt.sv
// Iterative SPECK128/128 encryptor: one round plus one key-schedule step per clock.
// A start in IDLE captures key/plaintext; ciphertext and a finished pulse appear ROUNDS clocks later.
module speck_iter_encrypt #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         signal_start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         finished,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t      state, state_nxt;
  logic [63:0] x, y, k, l;
  logic [63:0] x_nxt, y_nxt, k_nxt, l_nxt;
  logic [4:0]  rnd;
  logic        capture, step, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (signal_start) state_nxt = RUN;
      RUN:     if (rnd == LAST_ROUND) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE:    capture = signal_start;
      RUN: begin
        step = 1'b1;
        last = (rnd == LAST_ROUND);
      end
      default: ;
    endcase
  end

  // Data round uses the current subkey k; the schedule then derives the next one.
  always_comb begin
    x_nxt = ({x[7:0], x[63:8]} + y) ^ k;
    y_nxt = {y[60:0], y[63:61]} ^ x_nxt;
    l_nxt = ({l[7:0], l[63:8]} + k) ^ {59'b0, rnd};
    k_nxt = {k[60:0], k[63:61]} ^ l_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      k          <= '0;
      l          <= '0;
      rnd        <= '0;
      ciphertext <= '0;
      finished   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (capture) begin
        x    <= plaintext[127:64];
        y    <= plaintext[63:0];
        l    <= key[127:64];
        k    <= key[63:0];
        rnd  <= '0;
        busy <= 1'b1;
      end else if (step) begin
        x   <= x_nxt;
        y   <= y_nxt;
        l   <= l_nxt;
        k   <= k_nxt;
        rnd <= rnd + 5'd1;
        if (last) begin
          ciphertext <= {x_nxt, y_nxt};
          finished   <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/speck_iter_encrypt.md
SPECK_ITER_ENCRYPT -- requirements
Module: speck_iter_encrypt

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, number of SPECK128/128 rounds applied; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port signal_start  input  1  start request, sampled on rising clk.
REQ-005 SHALL have port key  input  128  master key; key[127:64] = l0, key[63:0] = k0.
REQ-006 SHALL have port plaintext  input  128  input block; [127:64] = x, [63:0] = y.
REQ-007 SHALL have port ciphertext  output  128  result block, same x/y packing; registered.
REQ-008 SHALL have port finished  output  1  one-cycle completion pulse; registered.
REQ-009 SHALL have port busy  output  1  high while a block is in progress; registered.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and RUN.
REQ-011 SHALL, in IDLE with signal_start=1 at an edge, capture key and plaintext into internal x, y, k, l registers, clear the 5-bit round counter, set busy=1 and enter RUN.
REQ-012 SHALL, in IDLE with signal_start=0, hold all registers and outputs.
REQ-013 SHALL, on each RUN edge with round counter i, apply one round: x' = (ROR64(x,8) + y) ^ k; y' = ROL64(y,3) ^ x'.
REQ-014 SHALL, on the same edge, advance the key schedule: l' = (ROR64(l,8) + k) ^ {59'b0, i}; k' = ROL64(k,3) ^ l'; round i therefore uses subkey k_i.
REQ-015 SHALL compute all additions modulo 2^64, discarding the carry.
REQ-016 SHALL increment the round counter by 1 on each RUN edge.
REQ-017 SHALL, on the RUN edge where i = ROUNDS-1, load ciphertext = {x', y'}, set finished=1, set busy=0 and return to IDLE.
REQ-018 SHALL have a latency of exactly ROUNDS clocks, measured from the signal_start sampling edge N to the edge N+ROUNDS that raises finished.
REQ-019 SHALL drive finished high for exactly one cycle and clear it on the following edge.
REQ-020 SHALL ignore signal_start while in RUN; the block in progress completes unchanged.
REQ-021 SHALL ignore changes on key or plaintext after the capture edge.
REQ-022 SHALL accept signal_start in the cycle in which finished is high, since the FSM is then in IDLE; the new block starts while the previous ciphertext is retained.
REQ-023 SHALL hold ciphertext stable from a completion until the next completion or reset.
REQ-024 SHALL re-run on a signal_start that is held high continuously, producing one result per ROUNDS+1 cycles.

Reset
REQ-025 SHALL, when rst_n=0, asynchronously force state=IDLE, round counter=0, x=y=k=l=0, ciphertext=0, finished=0 and busy=0.
REQ-026 SHALL, when reset is asserted during RUN, abort the block with no finished pulse; the first signal_start after rst_n=1 starts a fresh block.
REQ-027 SHALL ignore signal_start while rst_n=0.

Verification
REQ-028 Known-answer test: key=128'h0f0e0d0c0b0a0908_0706050403020100, plaintext=128'h6c61766975716520_7469206564616d20, one-cycle signal_start -> finished pulses exactly 32 clocks later, ciphertext=128'ha65d985179783265_7860fedf5c570d18, and busy is high for 32 cycles.
REQ-029 Start ignored while busy: pulse signal_start again 10 cycles into the run, with different key and plaintext -> a single finished pulse at cycle 32, with the same KAT ciphertext.
REQ-030 Back-to-back: assert signal_start in the finished cycle with plaintext=0 and key=0 -> second finished pulse 32 cycles later; ciphertext holds the KAT value until that second pulse and matches the reference-model value for that input afterwards.
REQ-031 Reset mid-run: drop rst_n asynchronously at round 17 -> ciphertext, finished and busy read 0 immediately with no finished pulse; after release, the KAT run again passes.
REQ-032 Input stability: change key and plaintext every cycle after the capture edge -> the result equals the KAT ciphertext.
REQ-033 ROUNDS=1: KAT inputs -> finished at N+1, ciphertext = one round of the KAT plaintext under k0=64'h0706050403020100, checked against a software model.
